// File: rtl/aes_key_sched_if.sv
// Request/response bundle for the AES key scheduler: start/key inputs,
// status outputs and the round-key read port.
interface aes_key_sched_if;
   logic         start;
   logic [1:0]   key_len;
   logic [255:0] key_in;
   logic         busy;
   logic         done;
   logic         err;
   logic [3:0]   nr;
   logic [3:0]   rounds_ready;
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;

   modport master (
      output start, key_len, key_in, rd_idx,
      input  busy, done, err, nr, rounds_ready, rd_key
   );

   modport slave (
      input  start, key_len, key_in, rd_idx,
      output busy, done, err, nr, rounds_ready, rd_key
   );
endinterface

// File: rtl/aes_key_sched.sv
// AES-128/192/256 key expansion, one word per cycle, with a 15-entry
// round-key store readable while the schedule is still running.
module sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
      logic [7:0] p, s;
      p = '0;
      s = x;
      for (int k = 0; k < 8; k++) begin
         if (m[k]) p = p ^ s;
         s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] pw, inv;

   // Inverse as a^254 (square-and-multiply); maps 0 to 0 as AES requires.
   always_comb begin
      pw  = a;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         pw  = gmul(pw, pw);
         inv = gmul(inv, pw);
      end
      y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

module aes_key_sched #(
   parameter int MAX_NK = 8,
   parameter bit RD_REG = 1'b0
) (
   input logic           clk,
   input logic           reset,
   aes_key_sched_if.slave kif
);
   logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic                first_q, first_d;
   logic [3:0]          nr_q, nr_d, rr_q, rr_d;
   logic [2:0]          nkm1_q, nkm1_d, m_q, m_d;
   logic [5:0]          i_q, i_d;
   logic [7:0]          rcon_q, rcon_d;
   logic [255:0]        key_q, key_d;
   logic [7:0][31:0]    win_q, win_d;
   logic [127:0]        keys_q [0:14];
   logic [127:0]        keys_d [0:14];
   logic [127:0]        rd_key_q, rd_key_d, rd_val;
   logic [31:0]         sub_in, sub_out, w;
   logic [3:0]          req_nk;
   logic                legal;

   // win_q[0] is w[i-1], win_q[k] is w[i-1-k]
   assign sub_in = (m_q == 3'd0) ? {win_q[0][23:0], win_q[0][31:24]} : win_q[0];

   for (genvar g = 0; g < 4; g++) begin : g_sub
      sbox u_sbox (.a(sub_in[8*g +: 8]), .y(sub_out[8*g +: 8]));
   end

   always_comb begin
      if (first_q)
         w = key_q[255:224];
      else if (m_q == 3'd0)
         w = win_q[nkm1_q] ^ sub_out ^ {rcon_q, 24'h0};
      else if (nkm1_q == 3'd7 && m_q == 3'd4)
         w = win_q[nkm1_q] ^ sub_out;
      else
         w = win_q[nkm1_q] ^ win_q[0];
   end

   always_comb begin
      case (kif.key_len)
         2'b00:   req_nk = 4'd4;
         2'b01:   req_nk = 4'd6;
         2'b10:   req_nk = 4'd8;
         default: req_nk = 4'd0;
      endcase
      legal = (req_nk != 4'd0) && (int'(req_nk) <= MAX_NK);
   end

   always_comb begin
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      first_d = first_q;
      nr_d    = nr_q;
      rr_d    = rr_q;
      nkm1_d  = nkm1_q;
      m_d     = m_q;
      i_d     = i_q;
      rcon_d  = rcon_q;
      key_d   = key_q;
      win_d   = win_q;
      keys_d  = keys_q;
      if (busy_q) begin
         win_d = {win_q[6:0], w};
         i_d   = i_q + 6'd1;
         if (first_q) key_d = {key_q[223:0], 32'h0};
         if (!first_q && m_q == 3'd0)
            rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
         if (m_q == nkm1_q) begin
            m_d     = 3'd0;
            first_d = 1'b0;
         end else begin
            m_d = m_q + 3'd1;
         end
         if (i_q[1:0] == 2'b11) begin
            keys_d[i_q[5:2]] = {win_q[2], win_q[1], win_q[0], w};
            rr_d             = rr_q + 4'd1;
         end
         if (i_q == {nr_q, 2'b11}) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end else if (kif.start) begin
         if (legal) begin
            busy_d  = 1'b1;
            rr_d    = 4'd0;
            nr_d    = req_nk + 4'd6;
            nkm1_d  = 3'(req_nk - 4'd1);
            m_d     = 3'd0;
            i_d     = 6'd0;
            first_d = 1'b1;
            rcon_d  = 8'h01;
            key_d   = kif.key_in;
            win_d   = '0;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   assign rd_val   = (kif.rd_idx < rr_q) ? keys_q[kif.rd_idx] : '0;
   assign rd_key_d = rd_val;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         first_q  <= 1'b0;
         nr_q     <= '0;
         rr_q     <= '0;
         nkm1_q   <= '0;
         m_q      <= '0;
         i_q      <= '0;
         rcon_q   <= '0;
         key_q    <= '0;
         win_q    <= '0;
         rd_key_q <= '0;
         for (int k = 0; k < 15; k++) keys_q[k] <= '0;
      end else begin
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         first_q  <= first_d;
         nr_q     <= nr_d;
         rr_q     <= rr_d;
         nkm1_q   <= nkm1_d;
         m_q      <= m_d;
         i_q      <= i_d;
         rcon_q   <= rcon_d;
         key_q    <= key_d;
         win_q    <= win_d;
         rd_key_q <= rd_key_d;
         for (int k = 0; k < 15; k++) keys_q[k] <= keys_d[k];
      end
   end

   assign kif.busy         = busy_q;
   assign kif.done         = done_q;
   assign kif.err          = err_q;
   assign kif.nr           = nr_q;
   assign kif.rounds_ready = rr_q;
   assign kif.rd_key       = RD_REG ? rd_key_q : rd_val;
endmodule

// File: tb/tb_aes_key_sched.sv
// Bench for aes_key_sched: known-answer table, corner-case sequences and
// random keys against a word-array expansion model.
module tb_aes_key_sched;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   aes_key_sched_if bus ();
   aes_key_sched_if bus4 ();

   assign bus4.start   = bus.start;
   assign bus4.key_len = bus.key_len;
   assign bus4.key_in  = bus.key_in;

   aes_key_sched #(.MAX_NK(8), .RD_REG(1'b0)) u_dut  (.clk(clk), .reset(reset), .kif(bus.slave));
   aes_key_sched #(.MAX_NK(4), .RD_REG(1'b1)) u_dut4 (.clk(clk), .reset(reset), .kif(bus4.slave));

   int checks = 0;
   int errors = 0;
   int ncyc;

   logic [7:0]  sb [256];
   logic [31:0] wm [60];
   logic [7:0]  rcon_t [11];

   typedef struct {
      logic [1:0]   len;
      logic [255:0] key;
      logic [3:0]   ridx;
      logic [127:0] exp;
   } vec_t;
   vec_t vt [5];

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   // Polynomial product reduced by long division by x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
      return p[7:0];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gf_mul_ref(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                     ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
      rcon_t = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   endtask

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
   endfunction

   task automatic expand(input logic [255:0] key, input logic [1:0] len);
      int nk, total;
      logic [31:0] t;
      nk    = 4 + 2 * int'(len);
      total = 4 * (nk + 7);
      for (int i = 0; i < total; i++) begin
         if (i < nk) begin
            wm[i] = key[255 - 32*i -: 32];
         end else begin
            t = wm[i-1];
            if (i % nk == 0)
               t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk], 24'h0};
            else if (nk == 8 && i % nk == 4)
               t = subw(t);
            wm[i] = wm[i-nk] ^ t;
         end
      end
   endtask

   function automatic logic [127:0] rk(input int r);
      return {wm[4*r], wm[4*r+1], wm[4*r+2], wm[4*r+3]};
   endfunction

   // Called at a negedge; returns at the negedge just after the start edge.
   task automatic start_pulse(input logic [1:0] len, input logic [255:0] key);
      bus.start   = 1'b1;
      bus.key_len = len;
      bus.key_in  = key;
      @(negedge clk);
      bus.start = 1'b0;
      ncyc      = 0;
   endtask

   task automatic wait_done();
      while (!bus.done && ncyc < 100) begin
         @(negedge clk);
         ncyc++;
      end
      chk("done_seen", 128'(bus.done), 128'd1);
   endtask

   task automatic check_all(input logic [1:0] len);
      int nr;
      nr = 10 + 2 * int'(len);
      for (int r = 0; r < 16; r++) begin
         bus.rd_idx = 4'(r);
         @(negedge clk);
         chk($sformatf("rk%0d", r), bus.rd_key, (r <= nr) ? rk(r) : 128'h0);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, 128'(bus.busy), 0);
      chk({tag, "_done"}, 128'(bus.done), 0);
      chk({tag, "_err"},  128'(bus.err), 0);
      chk({tag, "_nr"},   128'(bus.nr), 0);
      chk({tag, "_rr"},   128'(bus.rounds_ready), 0);
      chk({tag, "_rk"},   bus.rd_key, 0);
      chk({tag, "_rk4"},  bus4.rd_key, 0);
      chk({tag, "_busy4"}, 128'(bus4.busy), 0);
   endtask

   initial begin
      logic [255:0] k1, k2;
      logic [1:0]   ln;
      reset       = 1'b0;
      bus.start   = 1'b0;
      bus.key_len = 2'b00;
      bus.key_in  = '0;
      bus.rd_idx  = 4'd0;
      bus4.rd_idx = 4'd0;
      build_sbox();

      vt[0] = '{2'b00, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4'd10,
                128'h13111d7fe3944a17f307a78b4d2b30c5};
      vt[1] = '{2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4'd0,
                128'h2b7e151628aed2a6abf7158809cf4f3c};
      vt[2] = '{2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4'd10,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vt[3] = '{2'b01, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 4'd12,
                128'ha4970a331a78dc09c418c271e3a41d5d};
      vt[4] = '{2'b10, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 4'd14,
                128'h24fc79ccbf0979e9371ac23c6d68de36};

      #12;
      chk_zero("rst");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Known-answer vectors
      for (int v = 0; v < 5; v++) begin
         start_pulse(vt[v].len, vt[v].key);
         chk("busy_on", 128'(bus.busy), 1);
         chk("err4", 128'(bus4.err), 128'(vt[v].len != 2'b00));
         wait_done();
         chk("latency", 128'(ncyc), 128'(4 * (11 + 2 * int'(vt[v].len))));
         chk("nr", 128'(bus.nr), 128'(10 + 2 * int'(vt[v].len)));
         chk("rr", 128'(bus.rounds_ready), 128'(11 + 2 * int'(vt[v].len)));
         bus.rd_idx = vt[v].ridx;
         #1;
         chk($sformatf("kat%0d", v), bus.rd_key, vt[v].exp);
         @(negedge clk);
         chk("done_pulse", 128'(bus.done), 0);
         expand(vt[v].key, vt[v].len);
         check_all(vt[v].len);
      end

      // Illegal key_len: err pulse, stored AES-256 keys untouched
      start_pulse(2'b11, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      chk("ill_err", 128'(bus.err), 1);
      chk("ill_err4", 128'(bus4.err), 1);
      chk("ill_busy", 128'(bus.busy), 0);
      chk("ill_rr", 128'(bus.rounds_ready), 15);
      @(negedge clk);
      chk("ill_err_pulse", 128'(bus.err), 0);
      check_all(2'b10);

      // Start pulsed mid-schedule is ignored
      k1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      expand(k1, 2'b10);
      start_pulse(2'b10, k1);
      repeat (9) begin @(negedge clk); ncyc++; end
      bus.start   = 1'b1;
      bus.key_len = 2'b00;
      bus.key_in  = ~k1;
      @(negedge clk);
      ncyc++;
      bus.start = 1'b0;
      chk("mid_err", 128'(bus.err), 0);
      chk("mid_busy", 128'(bus.busy), 1);
      wait_done();
      chk("mid_latency", 128'(ncyc), 60);
      check_all(2'b10);

      // Start in the same cycle as done is accepted
      k1 = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      k2 = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      start_pulse(2'b00, k1);
      wait_done();
      expand(k2, 2'b00);
      start_pulse(2'b00, k2);
      chk("bb_busy", 128'(bus.busy), 1);
      chk("bb_rr", 128'(bus.rounds_ready), 0);
      chk("bb_done", 128'(bus.done), 0);
      wait_done();
      chk("bb_latency", 128'(ncyc), 44);
      check_all(2'b00);

      // Early reads: combinational and registered paths
      k1 = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      expand(k1, 2'b00);
      bus.rd_idx  = 4'd0;
      bus4.rd_idx = 4'd0;
      start_pulse(2'b00, k1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         ncyc = k;
         if (k == 3) begin
            chk("er_rr3", 128'(bus.rounds_ready), 0);
            chk("er_rk3", bus.rd_key, 0);
         end
         if (k == 4) begin
            chk("er_rr4", 128'(bus.rounds_ready), 1);
            chk("er_rk4", bus.rd_key, rk(0));
            chk("er_reg4", bus4.rd_key, 0);
         end
         if (k == 5) chk("er_reg5", bus4.rd_key, rk(0));
      end
      wait_done();
      chk("er_latency", 128'(ncyc), 44);

      // Reset mid AES-256 schedule, then a clean AES-128 run
      start_pulse(2'b10, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      repeat (20) @(negedge clk);
      reset = 1'b0;
      #1;
      chk_zero("abort");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      start_pulse(vt[0].len, vt[0].key);
      wait_done();
      chk("post_latency", 128'(ncyc), 44);
      chk("post_rr", 128'(bus.rounds_ready), 11);
      bus.rd_idx = 4'd10;
      #1;
      chk("post_kat", bus.rd_key, vt[0].exp);
      @(negedge clk);

      // Random keys in all modes
      for (int n = 0; n < 6; n++) begin
         ln = 2'($urandom_range(0, 2));
         k1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         expand(k1, ln);
         start_pulse(ln, k1);
         wait_done();
         chk("rnd_latency", 128'(ncyc), 128'(4 * (11 + 2 * int'(ln))));
         chk("rnd_nr", 128'(bus.nr), 128'(10 + 2 * int'(ln)));
         check_all(ln);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/aes_key_sched.md
AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
REQ-001 The block SHALL have parameter MAX_NK, default 8, giving the largest key size supported in 32-bit words (4, 6 or 8).
REQ-002 The block SHALL have parameter RD_REG, default 0, selecting a combinational read (0) or a registered read with 1-cycle latency (1).
REQ-003 Clock: clk, input, 1 bit; all state changes on its rising edge.
REQ-004 Reset: reset, input, 1 bit; asynchronous, active-low.
REQ-005 start, input, 1 bit: request a new key schedule.
REQ-006 key_len, input, 2 bits: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = illegal.
REQ-007 key_in, input, 256 bits: cipher key, left-aligned; word w0 = key_in[255:224]; unused LSBs are ignored.
REQ-008 busy, output, 1 bit: schedule in progress.
REQ-009 done, output, 1 bit: one-cycle pulse when the schedule is complete.
REQ-010 err, output, 1 bit: one-cycle pulse when a start is rejected.
REQ-011 nr, output, 4 bits: latched round count (10, 12 or 14).
REQ-012 rounds_ready, output, 4 bits: number of complete round keys stored, 0 to 15.
REQ-013 rd_idx, input, 4 bits: round-key read index.
REQ-014 rd_key, output, 128 bits: round key rd_idx, {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in the MSBs.

Function
REQ-015 Modes SHALL map to Nk = 4, 6, 8 and Nr = 10, 12, 14, giving 44, 52 and 60 total words.
REQ-016 A start SHALL be accepted only when busy=0 and the key_len Nk <= MAX_NK; key_in and key_len are latched on that edge.
REQ-017 A rejected start (key_len=11, Nk > MAX_NK, or start while busy=1) SHALL cause:
- err=1 on the next cycle, except when busy=1, where the start is silently ignored;
- no change to stored keys, nr or rounds_ready.
REQ-018 An accepted start SHALL do the following on the next edge:
- set busy=1, clear rounds_ready to 0, load nr, and set word index i=0;
- previously stored round keys become invalid.
REQ-019 While busy=1, the block SHALL produce exactly one word w[i] per cycle, incrementing i each cycle.
REQ-020 Word generation for i < Nk SHALL be w[i] = the i-th key word.
REQ-021 Word generation for i >= Nk SHALL be w[i] = w[i-Nk] ^ t, with t defined by the first matching case:
- if i mod Nk = 0: t = SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk], 24'h0};
- else if Nk = 8 and i mod Nk = 4: t = SubWord(w[i-1]);
- else: t = w[i-1].
REQ-022 Word operations SHALL be defined as follows:
- RotWord(x) = {x[23:0], x[31:24]};
- SubWord applies the AES S-box bytewise using four instances of the team SBox module;
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- For each mode, the highest Rcon index actually used is 10 (AES-128), 8 (AES-192) and 7 (AES-256).
REQ-023 An 8-word sliding window SHALL hold w[i-8..i-1]; no full word array is kept.
REQ-024 When i mod 4 = 3, the block SHALL assemble the four words into round key i/4, write it to a 15-entry storage array, and increment rounds_ready on the same edge.
REQ-025 On the cycle of the last word (i = 4(Nr+1)-1), the block SHALL write the final round key; on the next cycle it SHALL set busy=0 and done=1 for one cycle, with rounds_ready = Nr+1.
REQ-026 Throughput SHALL be as follows:
- start accepted at edge T means word i is written at edge T+1+i;
- round key r is readable from edge T+4r+4;
- done is high in the cycle after edge T+4(Nr+1).
REQ-027 Read behaviour SHALL be:
- RD_REG=0: rd_key reflects rd_idx in the same cycle;
- RD_REG=1: rd_key is registered, 1-cycle latency;
- rd_idx >= rounds_ready returns 128'h0;
- reads are legal while busy, so a cipher may consume keys early.
REQ-028 A start asserted in the same cycle that done is high SHALL be accepted, because busy is already 0.

Reset
REQ-029 While reset=0, the block SHALL hold the following values:
- busy=0, done=0, err=0, nr=0, rounds_ready=0, rd_key=0;
- window, storage and word index cleared.
REQ-030 A reset asserted mid-schedule SHALL abort the schedule immediately; the first post-reset start SHALL behave as from power-up.

Verification
REQ-031 The AES-128 case SHALL pass: key_in = 000102030405060708090a0b0c0d0e0f<<128, key_len=00 -> done 45 cycles after start, rounds_ready=11, rd_idx=10 gives 13111d7fe3944a17f307a78b4d2b30c5.
REQ-032 The second AES-128 vector SHALL pass: key 2b7e151628aed2a6abf7158809cf4f3c -> rd_idx=0 returns the key, rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-033 The AES-192 case SHALL pass: key 000102...1617, key_len=01 -> done after 53 cycles, nr=12, rd_idx=12 gives a4970a331a78dc09c418c271e3a41d5d.
REQ-034 The AES-256 case SHALL pass: key 000102...1e1f, key_len=10 -> done after 61 cycles, nr=14, rd_idx=14 gives 24fc79ccbf0979e9371ac23c6d68de36.
REQ-035 The rejection cases SHALL pass:
- key_len=11 -> err pulse, busy stays 0, stored keys unchanged;
- with MAX_NK=4, key_len=10 -> err pulse;
- start pulsed mid-schedule -> ignored, final keys still correct.
REQ-036 The reset-abort and early-read case SHALL pass:
- reset after 20 cycles of an AES-256 schedule -> all outputs 0;
- a subsequent AES-128 schedule gives the REQ-031 values;
- with RD_REG=1, reading rd_idx=0 during busy gives the key one cycle later.
